// File: rtl/fc_buf_loader.sv
// rtl/fc_buf_loader.sv - FC layer buffer loader: ifmap bytes, weight rows, start/done handshake (option: FC_LOADER_ZERO_FILL_EN)
module fc_buf_loader #(
    parameter int FC_SIZE = 120,
    parameter int DW      = 8,
    parameter int AW      = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_valid_i,
    output logic                  cfg_ready_o,
    input  logic [AW-1:0]         in_node_num_i,
    input  logic [AW-1:0]         out_node_num_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    input  logic [DW-1:0]         s_data_i,
    output logic                  ifmap_wren_o,
    output logic [AW-1:0]         ifmap_wrptr_o,
    output logic [DW-1:0]         ifmap_wdata_o,
    output logic                  wbuf_wren_o,
    output logic [AW*FC_SIZE-1:0] wbuf_wrptr_o,
    output logic [DW*FC_SIZE-1:0] wbuf_wdata_o,
    output logic                  start_o,
    output logic [AW-1:0]         in_node_num_o,
    output logic [AW-1:0]         out_node_num_o,
    input  logic                  fc_valid_i,
    input  logic                  fc_last_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD_IF = 3'd1,
        S_LOAD_W  = 3'd2,
        S_WR_ROW  = 3'd3,
        S_START   = 3'd4,
        S_WAIT_FC = 3'd5
    } state_t;

    state_t                  state_q;
    logic [AW-1:0]           in_num_q;
    logic [AW-1:0]           out_num_q;
    logic [AW-1:0]           col_q;
    logic [AW-1:0]           row_q;
    logic [DW*FC_SIZE-1:0]   stage_q;
    logic [DW*FC_SIZE-1:0]   stage_nx;
    logic                    accept;
    logic                    cfg_legal;

    assign cfg_ready_o    = (state_q == S_IDLE);
    assign busy_o         = (state_q != S_IDLE);
    assign s_ready_o      = (state_q == S_LOAD_IF) || (state_q == S_LOAD_W);
    assign accept         = s_valid_i && s_ready_o;
    assign in_node_num_o  = in_num_q;
    assign out_node_num_o = out_num_q;

    // A config is rejected when either count is zero or more outputs than lanes are requested.
    assign cfg_legal = (in_node_num_i != '0) && (out_node_num_i != '0) &&
                       (int'(out_node_num_i) <= FC_SIZE);

    // Staging row with the byte accepted this cycle merged in, so the row write can include the last lane.
    always_comb begin
        stage_nx = stage_q;
        if ((state_q == S_LOAD_W) && accept) begin
            for (int j = 0; j < FC_SIZE; j++) begin
                if (col_q == AW'(j)) begin
                    stage_nx[j*DW +: DW] = s_data_i;
                end
            end
        end
    end

    // Load sequencer: counters, staging row and all registered buffer/handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            in_num_q      <= '0;
            out_num_q     <= '0;
            col_q         <= '0;
            row_q         <= '0;
            stage_q       <= '0;
            ifmap_wren_o  <= 1'b0;
            ifmap_wrptr_o <= '0;
            ifmap_wdata_o <= '0;
            wbuf_wren_o   <= 1'b0;
            wbuf_wrptr_o  <= '0;
            wbuf_wdata_o  <= '0;
            start_o       <= 1'b0;
            done_o        <= 1'b0;
            err_o         <= 1'b0;
        end else begin
            ifmap_wren_o <= 1'b0;
            wbuf_wren_o  <= 1'b0;
            start_o      <= 1'b0;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
            stage_q      <= stage_nx;
            case (state_q)
                S_IDLE: begin
                    if (cfg_valid_i) begin
                        in_num_q  <= in_node_num_i;
                        out_num_q <= out_node_num_i;
                        if (cfg_legal) begin
                            col_q   <= '0;
                            state_q <= S_LOAD_IF;
                        end else begin
                            err_o   <= 1'b1;
                        end
                    end
                end
                S_LOAD_IF: begin
                    if (accept) begin
                        ifmap_wren_o  <= 1'b1;
                        ifmap_wrptr_o <= col_q;
                        ifmap_wdata_o <= s_data_i;
                        if (col_q == in_num_q - AW'(1)) begin
                            col_q   <= '0;
                            row_q   <= '0;
                            state_q <= S_LOAD_W;
`ifdef FC_LOADER_ZERO_FILL_EN
                            stage_q <= '0;
`endif
                        end else begin
                            col_q <= col_q + AW'(1);
                        end
                    end
                end
                S_LOAD_W: begin
                    if (accept) begin
                        if (col_q == out_num_q - AW'(1)) begin
                            wbuf_wren_o  <= 1'b1;
                            wbuf_wdata_o <= stage_nx;
                            wbuf_wrptr_o <= {FC_SIZE{row_q}};
                            state_q      <= S_WR_ROW;
                        end else begin
                            col_q <= col_q + AW'(1);
                        end
                    end
                end
                S_WR_ROW: begin
                    if (row_q != in_num_q - AW'(1)) begin
                        row_q   <= row_q + AW'(1);
                        col_q   <= '0;
                        state_q <= S_LOAD_W;
`ifdef FC_LOADER_ZERO_FILL_EN
                        stage_q <= '0;
`endif
                    end else begin
                        start_o <= 1'b1;
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    state_q <= S_WAIT_FC;
                end
                S_WAIT_FC: begin
                    if (fc_valid_i && fc_last_i) begin
                        done_o  <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fc_buf_loader.sv
// tb/tb_fc_buf_loader.sv - randomized self-checking bench for fc_buf_loader
module tb_fc_buf_loader;

    localparam int FC_SIZE = 120;
    localparam int DW      = 8;
    localparam int AW      = 7;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  cfg_valid_i;
    logic                  cfg_ready_o;
    logic [AW-1:0]         in_node_num_i;
    logic [AW-1:0]         out_node_num_i;
    logic                  s_valid_i;
    logic                  s_ready_o;
    logic [DW-1:0]         s_data_i;
    logic                  ifmap_wren_o;
    logic [AW-1:0]         ifmap_wrptr_o;
    logic [DW-1:0]         ifmap_wdata_o;
    logic                  wbuf_wren_o;
    logic [AW*FC_SIZE-1:0] wbuf_wrptr_o;
    logic [DW*FC_SIZE-1:0] wbuf_wdata_o;
    logic                  start_o;
    logic [AW-1:0]         in_node_num_o;
    logic [AW-1:0]         out_node_num_o;
    logic                  fc_valid_i;
    logic                  fc_last_i;
    logic                  busy_o;
    logic                  done_o;
    logic                  err_o;

    always #5 clk = ~clk;

    fc_buf_loader #(.FC_SIZE(FC_SIZE), .DW(DW), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
        .in_node_num_i(in_node_num_i), .out_node_num_i(out_node_num_i),
        .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i),
        .ifmap_wren_o(ifmap_wren_o), .ifmap_wrptr_o(ifmap_wrptr_o), .ifmap_wdata_o(ifmap_wdata_o),
        .wbuf_wren_o(wbuf_wren_o), .wbuf_wrptr_o(wbuf_wrptr_o), .wbuf_wdata_o(wbuf_wdata_o),
        .start_o(start_o), .in_node_num_o(in_node_num_o), .out_node_num_o(out_node_num_o),
        .fc_valid_i(fc_valid_i), .fc_last_i(fc_last_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: expected ifmap writes, expected rows and their weight bytes in order.
    int            exp_if_addr[$];
    int            exp_if_data[$];
    int            exp_row_idx[$];
    logic [DW-1:0] exp_w[$];
    int            cur_out = 1;
    int            wr_cnt  = 0;
    bit            err_ok  = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Output monitor: every buffer write is matched against the model queues.
    always @(negedge clk) begin : mon
        int   r;
        logic ptr_ok;
        if (ifmap_wren_o) begin
            if (exp_if_addr.size() == 0) begin
                check_eq("if_unexpected", 1, 0);
            end else begin
                check_eq("if_addr", 32'(ifmap_wrptr_o), exp_if_addr.pop_front());
                check_eq("if_data", 32'(ifmap_wdata_o), exp_if_data.pop_front());
            end
        end
        if (wbuf_wren_o) begin
            wr_cnt++;
            if (exp_row_idx.size() == 0) begin
                check_eq("w_unexpected", 1, 0);
            end else begin
                r = exp_row_idx.pop_front();
                ptr_ok = 1'b1;
                for (int j = 0; j < FC_SIZE; j++) begin
                    if (wbuf_wrptr_o[j*AW +: AW] !== AW'(r)) ptr_ok = 1'b0;
                end
                check_eq($sformatf("w_ptr_row%0d", r), 32'(ptr_ok), 1);
                for (int j = 0; j < cur_out; j++) begin
                    check_eq($sformatf("w_row%0d_lane%0d", r, j), 32'(wbuf_wdata_o[j*DW +: DW]),
                             32'(exp_w.pop_front()));
                end
`ifdef FC_LOADER_ZERO_FILL_EN
                for (int j = cur_out; j < FC_SIZE; j++) begin
                    check_eq($sformatf("w_row%0d_zero%0d", r, j), 32'(wbuf_wdata_o[j*DW +: DW]), 0);
                end
`endif
            end
        end
        if (err_o && !err_ok) check_eq("err_spurious", 1, 0);
    end

    // All tasks start and end at the drive point: 1 time unit after a rising edge.
    task automatic send_cfg(input int nin, input int nout);
        cfg_valid_i    = 1'b1;
        in_node_num_i  = AW'(nin);
        out_node_num_i = AW'(nout);
        @(posedge clk); #1;
        cfg_valid_i    = 1'b0;
    endtask

    task automatic check_illegal(input int nin, input int nout);
        err_ok = 1'b1;
        send_cfg(nin, nout);
        @(negedge clk);
        check_eq("err_pulse", 32'(err_o), 1);
        check_eq("err_cfg_ready", 32'(cfg_ready_o), 1);
        check_eq("err_busy", 32'(busy_o), 0);
        @(negedge clk);
        check_eq("err_one_cycle", 32'(err_o), 0);
        check_eq("err_still_idle", 32'(cfg_ready_o), 1);
        err_ok = 1'b0;
        @(posedge clk); #1;
    endtask

    // wbase < 0 gives random bytes; otherwise ifmap = 1,2,.. and weights = wbase, wbase+1, ..
    // stop_after < 0 streams everything and completes the FC handshake.
    task automatic run_load(input int nin, input int nout, input int gap, input int wbase,
                            input bit poke, input int stop_after);
        logic [DW-1:0] q[$];
        logic [DW-1:0] b;
        int  lim, idx, cyc_i;
        bit  ph, acc;
        cur_out = nout;
        wr_cnt  = 0;
        for (int k = 0; k < nin; k++) begin
            b = (wbase < 0) ? DW'($urandom) : DW'(k + 1);
            q.push_back(b);
            exp_if_addr.push_back(k);
            exp_if_data.push_back(int'(b));
        end
        for (int r = 0; r < nin; r++) begin
            exp_row_idx.push_back(r);
            for (int j = 0; j < nout; j++) begin
                b = (wbase < 0) ? DW'($urandom) : DW'(wbase + r * nout + j);
                q.push_back(b);
                exp_w.push_back(b);
            end
        end
        send_cfg(nin, nout);
        lim   = (stop_after < 0) ? q.size() : stop_after;
        idx   = 0;
        cyc_i = 0;
        ph    = 1'b0;
        while (idx < lim && cyc_i < 20000) begin
            case (gap)
                1:       s_valid_i = ph;
                2:       s_valid_i = ($urandom_range(0, 2) != 0);
                default: s_valid_i = 1'b1;
            endcase
            ph       = ~ph;
            s_data_i = q[idx];
            if (poke && cyc_i == 2) begin
                cfg_valid_i    = 1'b1;
                in_node_num_i  = '0;
                out_node_num_i = '0;
            end else begin
                cfg_valid_i    = 1'b0;
            end
            @(negedge clk);
            acc = s_valid_i && s_ready_o;
            @(posedge clk); #1;
            if (acc) idx++;
            cyc_i++;
        end
        s_valid_i   = 1'b0;
        cfg_valid_i = 1'b0;
        if (idx < lim) check_eq("stream_timeout", idx, lim);
        if (stop_after >= 0) return;
        @(negedge clk);
        check_eq("start_t1", 32'(start_o), 0);
        check_eq("s_ready_wr_row", 32'(s_ready_o), 0);
        @(negedge clk);
        check_eq("start_t2", 32'(start_o), 1);
        @(negedge clk);
        check_eq("start_one_cycle", 32'(start_o), 0);
        check_eq("busy_wait_fc", 32'(busy_o), 1);
        check_eq("s_ready_wait_fc", 32'(s_ready_o), 0);
        check_eq("wbuf_write_count", wr_cnt, nin);
        check_eq("if_queue_drained", exp_if_addr.size(), 0);
        check_eq("row_queue_drained", exp_row_idx.size(), 0);
        check_eq("in_node_num_o", 32'(in_node_num_o), nin);
        check_eq("out_node_num_o", 32'(out_node_num_o), nout);
        fc_valid_i = 1'b1;
        fc_last_i  = 1'b0;
        @(posedge clk); #1;
        fc_last_i  = 1'b1;
        @(negedge clk);
        check_eq("not_done_before_last", 32'(busy_o), 1);
        @(posedge clk); #1;
        fc_valid_i = 1'b0;
        fc_last_i  = 1'b0;
        @(negedge clk);
        check_eq("done_pulse", 32'(done_o), 1);
        check_eq("idle_after_done", 32'(busy_o), 0);
        check_eq("cfg_ready_after_done", 32'(cfg_ready_o), 1);
        @(negedge clk);
        check_eq("done_one_cycle", 32'(done_o), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n          = 1'b0;
        cfg_valid_i    = 1'b0;
        in_node_num_i  = '0;
        out_node_num_i = '0;
        s_valid_i      = 1'b0;
        s_data_i       = '0;
        fc_valid_i     = 1'b0;
        fc_last_i      = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_cfg_ready", 32'(cfg_ready_o), 1);
        check_eq("rst_busy", 32'(busy_o), 0);
        check_eq("rst_s_ready", 32'(s_ready_o), 0);
        check_eq("rst_enables", 32'({ifmap_wren_o, wbuf_wren_o, start_o, done_o, err_o}), 0);
        check_eq("rst_in_num", 32'(in_node_num_o), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_load(4, 3, 0, 10, 1'b0, -1);
        run_load(4, 3, 1, 10, 1'b0, -1);

        check_illegal(4, 121);
        check_illegal(0, 3);
        check_illegal(5, 0);

        run_load(1, 120, 0, -1, 1'b0, -1);
        run_load(1, 2, 0, 7, 1'b0, -1);

        run_load(4, 3, 0, 10, 1'b0, 10);
        @(negedge clk);
        @(posedge clk); #1;
        rst_n     = 1'b0;
        s_valid_i = 1'b1;
        exp_if_addr.delete();
        exp_if_data.delete();
        exp_row_idx.delete();
        exp_w.delete();
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("abort_enables", 32'({ifmap_wren_o, wbuf_wren_o, start_o, done_o}), 0);
        check_eq("abort_idle", 32'(cfg_ready_o), 1);
        check_eq("abort_busy", 32'(busy_o), 0);
        check_eq("abort_s_ready", 32'(s_ready_o), 0);
        @(posedge clk); #1;
        rst_n     = 1'b1;
        s_valid_i = 1'b0;
        @(posedge clk); #1;

        for (int t = 0; t < 8; t++) begin
            run_load($urandom_range(1, 8), $urandom_range(1, 120), $urandom_range(0, 2), -1,
                     1'b1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
